// File: rtl/shift_tx_ctrl.sv
// Paced word serializer sequencer for the universal shift register: load pulse, WIDTH shift
// strobes every DIV clocks, then a done pulse. Define SHIFT_TX_BUF_EN for a one-word holding buffer.
module shift_tx_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sh_par,
  output logic             sh_ld,
  output logic             sh_shift,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DivMax = DW'(DIV - 1);
  localparam logic [BW-1:0] BitMax = BW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             strobe;
  logic             accept;

`ifdef SHIFT_TX_BUF_EN
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  assign in_ready = !buf_full_q;
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept = in_valid && in_ready;
  assign strobe = (state_q == StShift) && (div_q == DivMax);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    par_d   = par_q;
`ifdef SHIFT_TX_BUF_EN
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    // Words arriving while a word is in flight park in the buffer.
    if (accept && (state_q != StIdle)) begin
      buf_full_d = 1'b1;
      buf_d      = in_data;
    end
`endif
    case (state_q)
      StIdle: begin
`ifdef SHIFT_TX_BUF_EN
        if (buf_full_q) begin
          state_d    = StLoad;
          par_d      = buf_q;
          buf_full_d = 1'b0;
        end else if (accept) begin
          state_d = StLoad;
          par_d   = in_data;
        end
`else
        if (accept) begin
          state_d = StLoad;
          par_d   = in_data;
        end
`endif
      end
      StLoad: begin
        state_d = StShift;
        div_d   = '0;
        bit_d   = '0;
      end
      StShift: begin
        if (strobe) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BitMax) state_d = StDone;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
`ifdef SHIFT_TX_BUF_EN
        // Pop straight into the next load so back-to-back words skip IDLE.
        if (buf_full_q) begin
          state_d    = StLoad;
          par_d      = buf_q;
          buf_full_d = accept;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      par_q   <= '0;
`ifdef SHIFT_TX_BUF_EN
      buf_full_q <= 1'b0;
      buf_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
`ifdef SHIFT_TX_BUF_EN
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
`endif
    end
  end

  assign sh_par   = par_q;
  assign sh_ld    = (state_q == StLoad);
  assign sh_shift = strobe;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: WIDTH=8/DIV=4 main instance plus a DIV=1 instance.
// Buffer-specific expectations follow SHIFT_TX_BUF_EN.
module tb_shift_tx_ctrl;

`ifdef SHIFT_TX_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic [7:0] sh_par, sh_par2;
  logic       sh_ld, sh_ld2, sh_shift, sh_shift2, busy, busy2, done, done2;

  int vecs = 0;
  int errs = 0;
  int cnt_ld, cnt_done, cnt_sh;

  always #5 clk = ~clk;

  shift_tx_ctrl #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sh_par(sh_par), .sh_ld(sh_ld), .sh_shift(sh_shift), .busy(busy), .done(done)
  );

  shift_tx_ctrl #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .sh_par(sh_par2), .sh_ld(sh_ld2), .sh_shift(sh_shift2), .busy(busy2), .done(done2)
  );

  // Observed vector order: {in_ready, busy, sh_ld, sh_shift, done}
  function automatic logic [4:0] ov();
    return {in_ready, busy, sh_ld, sh_shift, done};
  endfunction

  function automatic logic [4:0] ov2();
    return {in_ready2, busy2, sh_ld2, sh_shift2, done2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] e;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_valid2 = 1'b1; in_data2 = 8'hAA;

    // 1: reset held for 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {27'd0, ov()}, {27'd0, 5'b10000});
      check("rst_par", {24'd0, sh_par}, 32'h0);
      check("rst_outs_div1", {27'd0, ov2()}, {27'd0, 5'b10000});
    end
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    tick();

    // 2 (+3 without buffer): 8'h5C accepted in cycle 0
    in_valid = 1'b1; in_data = 8'h5C;
    check("t2_ready0", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      if (!BufEn && c == 3) begin in_valid = 1'b1; in_data = 8'hA5; end
      if (!BufEn && c == 10) in_data = 8'h3C;
      e = {(BufEn || c >= 35), (c <= 34), (c == 1),
           (c >= 5 && c <= 33 && (c % 4) == 1), (c == 34)};
      check($sformatf("t2_c%0d", c), {27'd0, ov()}, {27'd0, e});
      if (c == 1) check("t2_par", {24'd0, sh_par}, 32'h5C);
    end
    if (!BufEn) begin
      tick();
      in_valid = 1'b0;
      check("t3_ld", {31'd0, sh_ld}, 32'd1);
      check("t3_par", {24'd0, sh_par}, 32'h3C);
      cnt_ld = 0; cnt_done = 0;
      for (int c = 37; c <= 72; c++) begin
        tick();
        cnt_ld += int'(sh_ld);
        cnt_done += int'(done);
      end
      check("t3_extra_ld", cnt_ld, 0);
      check("t3_done_cnt", cnt_done, 1);
      check("t3_par_hold", {24'd0, sh_par}, 32'h3C);
      check("t3_idle", {27'd0, ov()}, {27'd0, 5'b10000});
    end

    // 4: reset after the 3rd strobe
    in_valid = 1'b1; in_data = 8'h77;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      if (c == 13) check("t4_strobe3", {31'd0, sh_shift}, 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_outs", {27'd0, ov()}, {27'd0, 5'b10000});
    check("t4_rst_par", {24'd0, sh_par}, 32'h0);
    cnt_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cnt_done += int'(done);
    end
    check("t4_no_done", cnt_done, 0);
    in_valid = 1'b1; in_data = 8'h0F;
    check("t4_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) begin
        in_valid = 1'b0;
        check("t4_ld", {31'd0, sh_ld}, 32'd1);
        check("t4_par", {24'd0, sh_par}, 32'h0F);
      end
      if (c == 34) check("t4_done", {31'd0, done}, 32'd1);
    end
    tick();

    // 5: DIV=1 instance
    in_valid2 = 1'b1; in_data2 = 8'hFF;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) in_valid2 = 1'b0;
      e = {(BufEn || c >= 11), (c <= 10), (c == 1), (c >= 2 && c <= 9), (c == 10)};
      check($sformatf("t5_c%0d", c), {27'd0, ov2()}, {27'd0, e});
      if (c == 1) check("t5_par", {24'd0, sh_par2}, 32'hFF);
    end

`ifdef SHIFT_TX_BUF_EN
    // 6: back-to-back words through the buffer
    in_valid = 1'b1; in_data = 8'h01;
    cnt_sh = 0;
    for (int c = 1; c <= 69; c++) begin
      tick();
      if (c == 1) in_data = 8'h80;
      if (c == 2) in_valid = 1'b0;
      cnt_sh += int'(sh_shift);
      e = {(c == 1 || c >= 35), (c <= 68), (c == 1 || c == 35),
           ((c >= 5 && c <= 33 && (c % 4) == 1) || (c >= 39 && c <= 67 && (c % 4) == 3)),
           (c == 34 || c == 68)};
      check($sformatf("t6_c%0d", c), {27'd0, ov()}, {27'd0, e});
      if (c == 1) check("t6_par1", {24'd0, sh_par}, 32'h01);
      if (c == 35) check("t6_par2", {24'd0, sh_par}, 32'h80);
    end
    check("t6_strobes", cnt_sh, 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
